// File: rtl/arm_dp_pkg.sv
// Shared definitions for the data-processing sequencer: ALU opcodes,
// condition codes, shift types, FSM states and condition evaluation.
package arm_dp_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 4;

    // Opcodes, identical to the ALU encoding
    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_EOR = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_RSB = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_ADC = 4'd5;
    localparam logic [3:0] OP_SBC = 4'd6;
    localparam logic [3:0] OP_RSC = 4'd7;
    localparam logic [3:0] OP_TST = 4'd8;
    localparam logic [3:0] OP_TEQ = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;
    localparam logic [3:0] OP_CMN = 4'd11;
    localparam logic [3:0] OP_ORR = 4'd12;
    localparam logic [3:0] OP_MOV = 4'd13;
    localparam logic [3:0] OP_BIC = 4'd14;
    localparam logic [3:0] OP_MVN = 4'd15;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Immediate shift types (instr[6:5])
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} dp_state_e;

    // nzcv ordering: [3]=N [2]=Z [1]=C [0]=V
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: return z;
            COND_NE: return !z;
            COND_CS: return c;
            COND_CC: return !c;
            COND_MI: return n;
            COND_PL: return !n;
            COND_VS: return v;
            COND_VC: return !v;
            COND_HI: return c && !z;
            COND_LS: return !c || z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return !z && (n == v);
            COND_LE: return z || (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Rotate right; an amount of zero returns the value unchanged
    function automatic logic [31:0] ror32(input logic [31:0] val, input logic [4:0] amt);
        return (val >> amt) | (val << (6'd32 - {1'b0, amt}));
    endfunction

endpackage

// File: rtl/dp_sequencer_if.sv
// Bus bundle between the sequencer and its decode, register-file and ALU
// neighbours. The master modport is the sequencer side.
interface dp_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [3:0]  rf_raddr_a;
    logic [3:0]  rf_raddr_b;
    logic [31:0] rf_rdata_a;
    logic [31:0] rf_rdata_b;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [3:0]  alu_control;
    logic [31:0] alu_operand_a;
    logic [31:0] alu_operand_b;
    logic        alu_reset;
    logic [31:0] alu_result;
    logic [3:0]  alu_nzcv;
    logic [3:0]  cpsr_nzcv;
    logic        done;
    logic        illegal;

    modport master (
        input  instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_result, alu_nzcv,
        output instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               alu_control, alu_operand_a, alu_operand_b, alu_reset,
               cpsr_nzcv, done, illegal
    );

    modport slave (
        output instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_result, alu_nzcv,
        input  instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               alu_control, alu_operand_a, alu_operand_b, alu_reset,
               cpsr_nzcv, done, illegal
    );
endinterface

// File: rtl/operand2_shifter.sv
// Combinational operand-2 builder: rotated 8-bit immediate, or Rm with an
// optional immediate shift when DP_BARREL_SHIFT_EN is defined. Without the
// macro, register operands pass through unshifted with carry = C.
module operand2_shifter
    import arm_dp_pkg::*;
(
    input  logic        imm_sel,
    input  logic [11:0] shift_field,
    input  logic [31:0] rm,
    input  logic        c_in,
    output logic [31:0] op2,
    output logic        carry_out
);

`ifdef DP_BARREL_SHIFT_EN
    logic        [4:0]  amt;
    logic        [32:0] lsl_t;
    logic        [32:0] lsr_t;
    logic signed [32:0] asr_t;

    // Extra bit on each shift captures the last bit shifted out
    assign amt   = shift_field[11:7];
    assign lsl_t = {1'b0, rm} << amt;
    assign lsr_t = {rm, 1'b0} >> amt;
    assign asr_t = $signed({rm, 1'b0}) >>> amt;
`endif

    // Select immediate rotation or register shift and its carry
    always_comb begin
        op2       = rm;
        carry_out = c_in;
        if (imm_sel) begin
            op2       = ror32({24'd0, shift_field[7:0]}, {shift_field[11:8], 1'b0});
            carry_out = (shift_field[11:8] == 4'd0) ? c_in : op2[31];
        end
`ifdef DP_BARREL_SHIFT_EN
        else begin
            case (shift_field[6:5])
                SH_LSL: begin
                    if (amt != 5'd0) {carry_out, op2} = lsl_t;
                end
                SH_LSR: begin
                    op2       = (amt == 5'd0) ? 32'd0 : lsr_t[32:1];
                    carry_out = (amt == 5'd0) ? rm[31] : lsr_t[0];
                end
                SH_ASR: begin
                    op2       = (amt == 5'd0) ? {32{rm[31]}} : asr_t[32:1];
                    carry_out = (amt == 5'd0) ? rm[31] : asr_t[0];
                end
                default: begin
                    // ROR #0 encodes RRX
                    op2       = (amt == 5'd0) ? {c_in, rm[31:1]} : ror32(rm, amt);
                    carry_out = (amt == 5'd0) ? rm[0] : op2[31];
                end
            endcase
        end
`endif
    end

endmodule

// File: rtl/dp_sequencer.sv
// Four-state sequencer for ARM data-processing instructions: latch, read
// operands and test condition, execute through the external ALU, write back.
// Optional immediate barrel shifts are enabled by DP_BARREL_SHIFT_EN.
module dp_sequencer
    import arm_dp_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    dp_sequencer_if.master bus
);

    dp_state_e   state, state_nxt;
    logic [31:0] instr_p0;
    logic [31:0] rn_p1, rm_p1;
    logic        pass_p1, illegal_p1;
    logic [31:0] res_p2;
    logic [1:0]  cv_p2;
    logic [3:0]  cpsr;

    logic [3:0]  opc;
    logic        s_bit, i_bit, is_test, is_arith, shift_bad, illegal_dec, commit;
    logic [31:0] op2, exec_res;
    logic        shc;
    logic        unused_alu_nz;

    assign opc      = instr_p0[24:21];
    assign s_bit    = instr_p0[20];
    assign i_bit    = instr_p0[25];
    assign is_test  = (opc[3:2] == 2'b10);
    assign is_arith = ((opc >= OP_SUB) && (opc <= OP_RSC)) || (opc == OP_CMP) || (opc == OP_CMN);

`ifdef DP_BARREL_SHIFT_EN
    assign shift_bad = 1'b0;
`else
    assign shift_bad = !i_bit && (instr_p0[11:4] != 8'd0);
`endif

    assign illegal_dec = (instr_p0[27:26] != 2'b00) || (instr_p0[31:28] == COND_NV) ||
                         (!i_bit && instr_p0[4]) || shift_bad || (is_test && !s_bit);
    assign commit      = pass_p1 && !illegal_p1;

    operand2_shifter u_shifter (
        .imm_sel    (i_bit),
        .shift_field(instr_p0[11:0]),
        .rm         (rm_p1),
        .c_in       (cpsr[1]),
        .op2        (op2),
        .carry_out  (shc)
    );

    // MOV bypasses the ALU; TST/TEQ flag results are formed locally
    always_comb begin
        exec_res = bus.alu_result;
        case (opc)
            OP_MOV:  exec_res = op2;
            OP_TST:  exec_res = rn_p1 & op2;
            OP_TEQ:  exec_res = rn_p1 ^ op2;
            default: exec_res = bus.alu_result;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: failing or illegal instructions skip EXEC
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.instr_valid) state_nxt = READ;
            READ: state_nxt = (illegal_dec || !cond_pass(instr_p0[31:28], cpsr)) ? WB : EXEC;
            EXEC: state_nxt = WB;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage registers: p0 at handshake, p1 at READ, p2 at EXEC, flags at WB
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_p0   <= '0;
            rn_p1      <= '0;
            rm_p1      <= '0;
            pass_p1    <= 1'b0;
            illegal_p1 <= 1'b0;
            res_p2     <= '0;
            cv_p2      <= '0;
            cpsr       <= '0;
        end else begin
            if (state == IDLE && bus.instr_valid) instr_p0 <= bus.instr;
            if (state == READ) begin
                rn_p1      <= bus.rf_rdata_a;
                rm_p1      <= bus.rf_rdata_b;
                pass_p1    <= cond_pass(instr_p0[31:28], cpsr);
                illegal_p1 <= illegal_dec;
            end
            if (state == EXEC) begin
                res_p2 <= exec_res;
                cv_p2  <= is_arith ? bus.alu_nzcv[1:0] : {shc, cpsr[0]};
            end
            if (state == WB && commit && s_bit)
                cpsr <= {res_p2[31], (res_p2 == 32'd0), cv_p2};
        end
    end

    assign unused_alu_nz     = ^bus.alu_nzcv[3:2];

    assign bus.instr_ready   = (state == IDLE);
    assign bus.rf_raddr_a    = instr_p0[19:16];
    assign bus.rf_raddr_b    = instr_p0[3:0];
    assign bus.rf_we         = (state == WB) && commit && !is_test;
    assign bus.rf_waddr      = instr_p0[15:12];
    assign bus.rf_wdata      = res_p2;
    assign bus.alu_control   = (state == EXEC) ? opc : 4'd0;
    assign bus.alu_operand_a = (state != EXEC) ? 32'd0 : ((opc == OP_MVN) ? op2 : rn_p1);
    assign bus.alu_operand_b = (state == EXEC) ? op2 : 32'd0;
    assign bus.alu_reset     = ~reset_n;
    assign bus.cpsr_nzcv     = cpsr;
    assign bus.done          = (state == WB);
    assign bus.illegal       = (state == WB) && illegal_p1;

endmodule

// File: tb/tb_dp_sequencer.sv
// Bench for dp_sequencer: register file and ALU models around the DUT,
// expected outcomes queued per instruction and compared at completion.
module tb_dp_sequencer;
    import arm_dp_pkg::*;

    typedef struct {
        logic [31:0] ins;
        int          lat;
        logic        ill;
        int          we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  nzcv;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dp_sequencer_if bus();
    dp_sequencer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    logic [31:0] rf [16];
    assign bus.rf_rdata_a = rf[bus.rf_raddr_a];
    assign bus.rf_rdata_b = rf[bus.rf_raddr_b];

    logic [32:0] alu_s;
    logic [31:0] alu_r, alu_a, alu_b;
    logic        alu_c, alu_v;

    // Reference ALU
    always_comb begin
        alu_a = bus.alu_operand_a;
        alu_b = bus.alu_operand_b;
        alu_s = '0;
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (bus.alu_control)
            OP_AND, OP_TST: alu_r = alu_a & alu_b;
            OP_EOR, OP_TEQ: alu_r = alu_a ^ alu_b;
            OP_SUB, OP_CMP: begin
                alu_s = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_r = alu_s[31:0]; alu_c = alu_s[32];
                alu_v = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            OP_RSB: begin
                alu_s = {1'b0, alu_b} + {1'b0, ~alu_a} + 33'd1;
                alu_r = alu_s[31:0]; alu_c = alu_s[32];
                alu_v = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_b[31]);
            end
            OP_ORR: alu_r = alu_a | alu_b;
            OP_MOV: alu_r = alu_b;
            OP_BIC: alu_r = alu_a & ~alu_b;
            OP_MVN: alu_r = ~alu_a;
            default: begin
                alu_s = {1'b0, alu_a} + {1'b0, alu_b};
                alu_r = alu_s[31:0]; alu_c = alu_s[32];
                alu_v = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
        endcase
        bus.alu_result = alu_r;
        bus.alu_nzcv   = {alu_r[31], (alu_r == 32'd0), alu_c, alu_v};
    end

    int n_chk = 0;
    int n_fail = 0;
    exp_t sb[$];
    exp_t e;
    int          obs_lat, obs_we_cnt;
    logic        obs_ill, obs_rdy;
    logic [3:0]  obs_wa, obs_nzcv;
    logic [31:0] obs_wd;

    // Drive one handshake and record what the DUT does until it is idle again
    task automatic issue(input logic [31:0] ins);
        int guard;
        obs_lat = 99; obs_ill = 1'bx; obs_we_cnt = 0; obs_wa = 'x; obs_wd = 'x;
        @(negedge clk);
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        guard = 0;
        while (!bus.instr_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instr = $urandom();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.rf_we) begin
                obs_we_cnt++; obs_wa = bus.rf_waddr; obs_wd = bus.rf_wdata;
            end
            if (bus.done) begin
                obs_lat = c; obs_ill = bus.illegal;
                break;
            end
        end
        @(negedge clk);
        if (bus.rf_we) obs_we_cnt++;
        obs_rdy  = bus.instr_ready;
        obs_nzcv = bus.cpsr_nzcv;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++;
        if ({bus.instr_ready, bus.done, bus.illegal, bus.rf_we, bus.alu_reset} !== 5'b10001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 10001", {bus.instr_ready, bus.done, bus.illegal, bus.rf_we, bus.alu_reset});
        end
        n_chk++;
        if (bus.cpsr_nzcv !== 4'b0000) begin
            n_fail++; $display("FAIL reset_cpsr: got %b want 0000", bus.cpsr_nzcv);
        end
        n_chk++;
        if ({bus.rf_waddr, bus.rf_wdata} !== 36'd0) begin
            n_fail++; $display("FAIL reset_wb: got %h/%h want 0/0", bus.rf_waddr, bus.rf_wdata);
        end
        n_chk++;
        if ({bus.alu_control, bus.alu_operand_a, bus.alu_operand_b} !== 68'd0) begin
            n_fail++; $display("FAIL reset_alu: got %h %h %h want zeros", bus.alu_control, bus.alu_operand_a, bus.alu_operand_b);
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({bus.alu_reset, bus.instr_ready} !== 2'b01) begin
            n_fail++; $display("FAIL reset_release: got %b want 01", {bus.alu_reset, bus.instr_ready});
        end
    endtask

    task automatic test_datapath();
        exp_t v[3] = '{
            '{32'hE2921001, 3, 1'b0, 1, 4'd1, 32'h80000000, 4'b1001},  // ADDS R1,R2,#1
            '{32'h03A030FF, 2, 1'b0, 0, 4'd0, 32'h0,        4'b1001},  // MOVEQ skipped
            '{32'hE3B0420F, 3, 1'b0, 1, 4'd4, 32'hF0000000, 4'b1011}   // MOVS R4,#F0000000
        };
        foreach (v[i]) begin
            sb.push_back(v[i]);
            issue(v[i].ins);
            e = sb.pop_front();
            n_chk++; if (obs_lat !== e.lat) begin n_fail++; $display("FAIL datapath_lat %h: got %0d want %0d", e.ins, obs_lat, e.lat); end
            n_chk++; if (obs_ill !== e.ill) begin n_fail++; $display("FAIL datapath_illegal %h: got %b want %b", e.ins, obs_ill, e.ill); end
            n_chk++; if (obs_we_cnt !== e.we) begin n_fail++; $display("FAIL datapath_we %h: got %0d want %0d", e.ins, obs_we_cnt, e.we); end
            if (e.we != 0) begin
                n_chk++; if ({obs_wa, obs_wd} !== {e.wa, e.wd}) begin n_fail++; $display("FAIL datapath_wb %h: got R%0d=%h want R%0d=%h", e.ins, obs_wa, obs_wd, e.wa, e.wd); end
            end
            n_chk++; if (obs_nzcv !== e.nzcv) begin n_fail++; $display("FAIL datapath_nzcv %h: got %b want %b", e.ins, obs_nzcv, e.nzcv); end
            n_chk++; if (obs_rdy !== 1'b1) begin n_fail++; $display("FAIL datapath_ready %h: got %b want 1", e.ins, obs_rdy); end
        end
    endtask

    task automatic test_cmp_cond();
        exp_t v[3] = '{
            '{32'hE1500000, 3, 1'b0, 0, 4'd0, 32'h0, 4'b0110},  // CMP R0,R0
            '{32'h13A03001, 2, 1'b0, 0, 4'd0, 32'h0, 4'b0110},  // MOVNE skipped
            '{32'h03A03001, 3, 1'b0, 1, 4'd3, 32'h1, 4'b0110}   // MOVEQ taken
        };
        foreach (v[i]) begin
            sb.push_back(v[i]);
            issue(v[i].ins);
            e = sb.pop_front();
            n_chk++; if (obs_lat !== e.lat) begin n_fail++; $display("FAIL cond_lat %h: got %0d want %0d", e.ins, obs_lat, e.lat); end
            n_chk++; if (obs_ill !== e.ill) begin n_fail++; $display("FAIL cond_illegal %h: got %b want %b", e.ins, obs_ill, e.ill); end
            n_chk++; if (obs_we_cnt !== e.we) begin n_fail++; $display("FAIL cond_we %h: got %0d want %0d", e.ins, obs_we_cnt, e.we); end
            if (e.we != 0) begin
                n_chk++; if ({obs_wa, obs_wd} !== {e.wa, e.wd}) begin n_fail++; $display("FAIL cond_wb %h: got R%0d=%h want R%0d=%h", e.ins, obs_wa, obs_wd, e.wa, e.wd); end
            end
            n_chk++; if (obs_nzcv !== e.nzcv) begin n_fail++; $display("FAIL cond_nzcv %h: got %b want %b", e.ins, obs_nzcv, e.nzcv); end
        end
    endtask

    task automatic test_shift();
`ifdef DP_BARREL_SHIFT_EN
        exp_t v[2] = '{
            '{32'hE1B05226, 3, 1'b0, 1, 4'd5, 32'h00000001, 4'b0010},  // MOVS R5,R6,LSR #4
            '{32'hE1B07006, 3, 1'b0, 1, 4'd7, 32'h0000001F, 4'b0010}   // MOVS R7,R6
        };
`else
        exp_t v[2] = '{
            '{32'hE1B05226, 2, 1'b1, 0, 4'd0, 32'h0,        4'b0110},
            '{32'hE1B07006, 3, 1'b0, 1, 4'd7, 32'h0000001F, 4'b0010}
        };
`endif
        foreach (v[i]) begin
            sb.push_back(v[i]);
            issue(v[i].ins);
            e = sb.pop_front();
            n_chk++; if (obs_lat !== e.lat) begin n_fail++; $display("FAIL shift_lat %h: got %0d want %0d", e.ins, obs_lat, e.lat); end
            n_chk++; if (obs_ill !== e.ill) begin n_fail++; $display("FAIL shift_illegal %h: got %b want %b", e.ins, obs_ill, e.ill); end
            n_chk++; if (obs_we_cnt !== e.we) begin n_fail++; $display("FAIL shift_we %h: got %0d want %0d", e.ins, obs_we_cnt, e.we); end
            if (e.we != 0) begin
                n_chk++; if ({obs_wa, obs_wd} !== {e.wa, e.wd}) begin n_fail++; $display("FAIL shift_wb %h: got R%0d=%h want R%0d=%h", e.ins, obs_wa, obs_wd, e.wa, e.wd); end
            end
            n_chk++; if (obs_nzcv !== e.nzcv) begin n_fail++; $display("FAIL shift_nzcv %h: got %b want %b", e.ins, obs_nzcv, e.nzcv); end
        end
    endtask

    task automatic test_illegal();
        exp_t v[4] = '{
            '{32'hF3A03001, 2, 1'b1, 0, 4'd0, 32'h0, 4'b0010},  // cond NV
            '{32'hE1A05316, 2, 1'b1, 0, 4'd0, 32'h0, 4'b0010},  // register shift
            '{32'hE1400000, 2, 1'b1, 0, 4'd0, 32'h0, 4'b0010},  // CMP without S
            '{32'hE5901000, 2, 1'b1, 0, 4'd0, 32'h0, 4'b0010}   // not data-processing
        };
        foreach (v[i]) begin
            sb.push_back(v[i]);
            issue(v[i].ins);
            e = sb.pop_front();
            n_chk++; if (obs_lat !== e.lat) begin n_fail++; $display("FAIL illegal_lat %h: got %0d want %0d", e.ins, obs_lat, e.lat); end
            n_chk++; if (obs_ill !== e.ill) begin n_fail++; $display("FAIL illegal_flag %h: got %b want %b", e.ins, obs_ill, e.ill); end
            n_chk++; if (obs_we_cnt !== e.we) begin n_fail++; $display("FAIL illegal_we %h: got %0d want %0d", e.ins, obs_we_cnt, e.we); end
            n_chk++; if (obs_nzcv !== e.nzcv) begin n_fail++; $display("FAIL illegal_nzcv %h: got %b want %b", e.ins, obs_nzcv, e.nzcv); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.instr = 32'hE2921001;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_chk++;
        if ({bus.instr_ready, bus.done, bus.rf_we, bus.cpsr_nzcv, bus.rf_waddr, bus.rf_wdata} !== {3'b100, 4'b0, 4'b0, 32'h0}) begin
            n_fail++; $display("FAIL midreset_outputs: ready/done/we=%b%b%b cpsr=%b wa=%h wd=%h want 100 0000 0 0",
                                bus.instr_ready, bus.done, bus.rf_we, bus.cpsr_nzcv, bus.rf_waddr, bus.rf_wdata);
        end
        n_chk++;
        if ({bus.alu_control, bus.alu_operand_a, bus.alu_operand_b} !== 68'd0) begin
            n_fail++; $display("FAIL midreset_alu: got %h %h %h want zeros", bus.alu_control, bus.alu_operand_a, bus.alu_operand_b);
        end
        @(negedge clk);
        n_chk++;
        if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL midreset_we: got %b want 0", bus.rf_we); end
        reset_n = 1'b1;
        sb.push_back('{32'hE3A08012, 3, 1'b0, 1, 4'd8, 32'h12, 4'b0000});  // MOV R8,#0x12
        issue(32'hE3A08012);
        e = sb.pop_front();
        n_chk++; if (obs_lat !== e.lat) begin n_fail++; $display("FAIL midreset_next_lat: got %0d want %0d", obs_lat, e.lat); end
        n_chk++; if (obs_we_cnt !== e.we) begin n_fail++; $display("FAIL midreset_next_we: got %0d want %0d", obs_we_cnt, e.we); end
        n_chk++; if ({obs_wa, obs_wd} !== {e.wa, e.wd}) begin n_fail++; $display("FAIL midreset_next_wb: got R%0d=%h want R%0d=%h", obs_wa, obs_wd, e.wa, e.wd); end
        n_chk++; if (obs_nzcv !== e.nzcv) begin n_fail++; $display("FAIL midreset_next_nzcv: got %b want %b", obs_nzcv, e.nzcv); end
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        for (int i = 0; i < 16; i++) rf[i] = 32'h100 + i;
        rf[0] = 32'd5;
        rf[2] = 32'h7FFFFFFF;
        rf[6] = 32'h0000001F;
        test_reset();
        test_datapath();
        test_cmp_cond();
        test_shift();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
